// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_bus_pkg
// Purpose  : Shared types and constants for the MIPS core data-memory bridge.
//            Holds the bridge state encoding and the bus access-size codes.
// Revision : 1.0  initial release
// ============================================================================
package mips_bus_pkg;

    // Bridge FSM states, encoded explicitly so waveforms stay readable
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } busState_t;

    // Access size codes carried on mem_sizeM / data_size
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage : mips_bus_pkg
`default_nettype wire

// File: rtl/dmem_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sram_bridge
// Purpose  : Converts the M-stage single-cycle data-memory access into an
//            SRAM-like split request/response transaction (req/addr_ok/
//            data_ok). The M stage is held on stall_memM until the access
//            completes; accesses flagged as excepting before issue are dropped.
// Options  : DMEM_SRAM_BRIDGE_BYPASS_EN - forward load data combinationally
//            and release the stall in the data_ok cycle itself.
// Revision : 1.0  initial release
// ============================================================================
module dmem_sram_bridge
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // only 32 is supported
) (
    input  logic              clk,
    input  logic              rst,
    // core M-stage side
    input  logic              mem_enM,
    input  logic [3:0]        mem_wenM,
    input  logic [1:0]        mem_sizeM,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [DATA_W-1:0] mem_write_dataM,
    input  logic              is_exceptM,
    input  logic              mem_advM,
    output logic [DATA_W-1:0] readdataM,
    output logic              stall_memM,
    // SRAM-like bus side
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    busState_t         r_state;
    busState_t         w_stateNext;
    logic              w_stall;
    logic              w_issue;      // start a new access from IDLE
    logic              w_respDone;   // a response is accepted this cycle
    logic              w_kill;       // the in-flight access must be discarded
    logic              r_killed;     // exception seen earlier in this access
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_readData;

    // An exception raised at any point after issue discards the response
    assign w_kill = r_killed | is_exceptM;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and stall decode
    always_comb begin
        w_stateNext = r_state;
        w_stall     = 1'b0;
        w_issue     = 1'b0;
        w_respDone  = 1'b0;
        case (r_state)
            IDLE: begin
                // Stall in the issue cycle so the instruction cannot leave M
                if (mem_enM && !is_exceptM) begin
                    w_issue     = 1'b1;
                    w_stall     = 1'b1;
                    w_stateNext = REQ;
                end
            end
            REQ: begin
                w_stall = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        w_respDone  = 1'b1;
                        w_stateNext = w_kill ? IDLE : DONE;
                    end else begin
                        w_stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                w_stall = 1'b1;
                if (data_data_ok) begin
                    w_respDone  = 1'b1;
                    w_stateNext = w_kill ? IDLE : DONE;
                end
            end
            DONE: begin
                // mem_advM is only honoured here; earlier it is a core error
                if (mem_advM) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
`ifdef DMEM_SRAM_BRIDGE_BYPASS_EN
        // Release the core in the response cycle; skip DONE if it advances now.
        // Killed accesses keep the stall until the response, as without bypass.
        if (w_respDone && !w_kill) begin
            w_stall = 1'b0;
            if (mem_advM) begin
                w_stateNext = IDLE;
            end
        end
`endif
    end

    // Request capture, kill tracking and load-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr       <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_readData <= '0;
            r_killed   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_wr    <= |mem_wenM;
                r_size  <= mem_sizeM;
                r_addr  <= aluoutM;
                r_wdata <= mem_write_dataM;
            end
            if (w_respDone && !w_kill && !r_wr) begin
                r_readData <= data_rdata;
            end
            if (w_respDone) begin
                r_killed <= 1'b0;
            end else if ((r_state == REQ || r_state == WAIT) && is_exceptM) begin
                r_killed <= 1'b1;
            end
        end
    end

    assign data_req   = (r_state == REQ);
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wdata = r_wdata;
    assign stall_memM = w_stall;

`ifdef DMEM_SRAM_BRIDGE_BYPASS_EN
    assign readdataM = (w_respDone && !w_kill && !r_wr) ? data_rdata : r_readData;
`else
    assign readdataM = r_readData;
`endif

endmodule : dmem_sram_bridge
`default_nettype wire
